// File: rtl/imm_splitter_pkg.sv
// rtl/imm_splitter_pkg.sv - shared types and constants for the immediate splitter
package imm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ONE  = 2'd1,
      HI   = 2'd2,
      LO   = 2'd3
   } imm_state_e;

   localparam int IMM_W  = 8;
   localparam int DATA_W = 16;

   localparam logic [IMM_W-1:0] SAT_POS = 8'h7F;
   localparam logic [IMM_W-1:0] SAT_NEG = 8'h80;

endpackage

// File: rtl/imm_splitter_if.sv
// rtl/imm_splitter_if.sv - input value and output beat handshake bundle
interface imm_splitter_if;
   import imm_pkg::*;

   logic              in_valid;
   logic [DATA_W-1:0] in_16b;
   logic              in_ready;
   logic              out_valid;
   logic              out_ready;
   logic [IMM_W-1:0]  out_8b;
   logic              out_last;
   logic              out_fits;

   modport slave (
      input  in_valid, in_16b, out_ready,
      output in_ready, out_valid, out_8b, out_last, out_fits
   );

   modport master (
      output in_valid, in_16b, out_ready,
      input  in_ready, out_valid, out_8b, out_last, out_fits
   );

endinterface

// File: rtl/imm_splitter_fit_check.sv
// rtl/imm_splitter_fit_check.sv - combinational 8-bit immediate fit test and clamp value
module imm_fit_check
   import imm_pkg::*;
(
   input  logic [DATA_W-1:0] data_i,
   output logic              fits_o,
   output logic [IMM_W-1:0]  sat_o
);

   logic [DATA_W-IMM_W:0] top_bits;

   // Bits above the immediate's sign bit must all copy it.
   assign top_bits = data_i[DATA_W-1:IMM_W-1];
   assign fits_o   = (&top_bits) || (~|top_bits);
   assign sat_o    = data_i[DATA_W-1] ? SAT_NEG : SAT_POS;

endmodule

// File: rtl/imm_splitter.sv
// rtl/imm_splitter.sv - narrows 16-bit values into one or two 8-bit immediate beats
// IMM_SPLITTER_SATURATE_EN: clamp non-fitting values to a single beat instead of splitting.
module imm_splitter
   import imm_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   imm_splitter_if.slave    io,
   output logic [CNT_W-1:0] ovf_cnt
);

   imm_state_e        state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [IMM_W-1:0]  out_8b_q, out_8b_d;
   logic              out_last_q, out_last_d;
   logic              out_fits_q, out_fits_d;
   logic [CNT_W-1:0]  ovf_q, ovf_d;

   logic              in_fits;
   logic [IMM_W-1:0]  in_sat;
   logic              in_xfer;
   logic              out_xfer;

   imm_fit_check u_fit (
      .data_i (io.in_16b),
      .fits_o (in_fits),
      .sat_o  (in_sat)
   );

   assign io.out_valid = (state_q != IDLE);
   assign out_xfer     = io.out_valid && io.out_ready;
   // A consumed last beat frees the slot in the same cycle, so singles stream without bubbles.
   assign io.in_ready  = (state_q == IDLE) || (out_xfer && out_last_q);
   assign in_xfer      = io.in_valid && io.in_ready;

   assign io.out_8b    = out_8b_q;
   assign io.out_last  = out_last_q;
   assign io.out_fits  = out_fits_q;
   assign ovf_cnt      = ovf_q;

`ifdef IMM_SPLITTER_SATURATE_EN
   logic unused_held;
   assign unused_held = ^data_q;
`else
   logic unused_sat;
   assign unused_sat = ^in_sat;
`endif

   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      out_8b_d   = out_8b_q;
      out_last_d = out_last_q;
      out_fits_d = out_fits_q;
      ovf_d      = ovf_q;

      case (state_q)
         IDLE: ;
         HI: begin
            if (out_xfer) begin
               state_d    = LO;
               out_8b_d   = data_q[IMM_W-1:0];
               out_last_d = 1'b1;
               out_fits_d = 1'b0;
            end
         end
         ONE, LO: begin
            if (out_xfer) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A new value only arrives in IDLE or alongside a last beat, so it overrides the above.
      if (in_xfer) begin
         data_d = io.in_16b;
         if (in_fits) begin
            state_d    = ONE;
            out_8b_d   = io.in_16b[IMM_W-1:0];
            out_last_d = 1'b1;
            out_fits_d = 1'b1;
         end else begin
`ifdef IMM_SPLITTER_SATURATE_EN
            state_d    = ONE;
            out_8b_d   = in_sat;
            out_last_d = 1'b1;
            out_fits_d = 1'b0;
`else
            state_d    = HI;
            out_8b_d   = io.in_16b[DATA_W-1:IMM_W];
            out_last_d = 1'b0;
            out_fits_d = 1'b0;
`endif
            if (ovf_q != '1) begin
               ovf_d = ovf_q + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         data_q     <= '0;
         out_8b_q   <= '0;
         out_last_q <= 1'b0;
         out_fits_q <= 1'b0;
         ovf_q      <= '0;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         out_8b_q   <= out_8b_d;
         out_last_q <= out_last_d;
         out_fits_q <= out_fits_d;
         ovf_q      <= ovf_d;
      end
   end

endmodule

// File: tb/tb_imm_splitter.sv
// tb/tb_imm_splitter.sv - self-checking bench for imm_splitter (vectors, corner sequences, random)
module tb_imm_splitter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] ovf1;
   logic [1:0] ovf2;

   imm_splitter_if bif();
   imm_splitter_if bif2();

   assign bif2.in_valid  = bif.in_valid;
   assign bif2.in_16b    = bif.in_16b;
   assign bif2.out_ready = bif.out_ready;

   imm_splitter #(.CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .io(bif), .ovf_cnt(ovf1));
   imm_splitter #(.CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .io(bif2), .ovf_cnt(ovf2));

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic       last;
      logic       fits;
   } beat_t;

   typedef struct {
      logic [7:0] d;
      logic       last;
      logic       fits;
      int         cyc;
   } cap_t;

   typedef struct {
      logic [15:0] val;
      int          n;
      logic [7:0]  b0;
      logic [7:0]  b1;
      logic        fits;
   } vec_t;

   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   int    ovf_m = 0;
   beat_t q[$];
   cap_t  cap[$];
   vec_t  vecs[8];
   logic  seen_ready;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   // Expected beats of one accepted value, straight from the fit/split/clamp rules.
   task automatic model_push(input logic [15:0] v);
      beat_t b;
      if (v[15:7] == 9'h000 || v[15:7] == 9'h1FF) begin
         b.d = v[7:0]; b.last = 1'b1; b.fits = 1'b1; q.push_back(b);
      end else begin
`ifdef IMM_SPLITTER_SATURATE_EN
         b.d = v[15] ? 8'h80 : 8'h7F; b.last = 1'b1; b.fits = 1'b0; q.push_back(b);
`else
         b.d = v[15:8]; b.last = 1'b0; b.fits = 1'b0; q.push_back(b);
         b.d = v[7:0];  b.last = 1'b1; b.fits = 1'b0; q.push_back(b);
`endif
         ovf_m++;
      end
   endtask

   task automatic step(input logic v, input logic [15:0] d, input logic r);
      logic exp_in_ready;
      cap_t c;
      @(negedge clk);
      bif.in_valid = v; bif.in_16b = d; bif.out_ready = r;
      #1;
      cyc++;
      exp_in_ready = (q.size() == 0) || (r && q.size() == 1);
      seen_ready = bif.in_ready;
      chk("out_valid", bif.out_valid, q.size() != 0);
      if (q.size() != 0) begin
         chk("out_8b", bif.out_8b, q[0].d);
         chk("out_last", bif.out_last, q[0].last);
         chk("out_fits", bif.out_fits, q[0].fits);
      end
      chk("in_ready", bif.in_ready, exp_in_ready);
      chk("ovf_cnt", ovf1, (ovf_m > 255) ? 255 : ovf_m);
      chk("ovf_cnt_w2", ovf2, (ovf_m > 3) ? 3 : ovf_m);
      if (q.size() != 0 && r) begin
         c.d = bif.out_8b; c.last = bif.out_last; c.fits = bif.out_fits; c.cyc = cyc;
         cap.push_back(c);
         void'(q.pop_front());
      end
      if (v && exp_in_ready) model_push(d);
   endtask

   function automatic vec_t mk(input logic [15:0] val, input int n, input logic [7:0] b0,
                               input logic [7:0] b1, input logic fits);
      vec_t t;
      t.val = val; t.n = n; t.b0 = b0; t.b1 = b1; t.fits = fits;
      return t;
   endfunction

   initial begin
      vecs[0] = mk(16'hFFF0, 1, 8'hF0, 8'h00, 1'b1);
      vecs[1] = mk(16'h007F, 1, 8'h7F, 8'h00, 1'b1);
      vecs[2] = mk(16'hFF80, 1, 8'h80, 8'h00, 1'b1);
      vecs[3] = mk(16'h0000, 1, 8'h00, 8'h00, 1'b1);
`ifdef IMM_SPLITTER_SATURATE_EN
      vecs[4] = mk(16'h1234, 1, 8'h7F, 8'h00, 1'b0);
      vecs[5] = mk(16'h0080, 1, 8'h7F, 8'h00, 1'b0);
      vecs[6] = mk(16'hFF7F, 1, 8'h80, 8'h00, 1'b0);
      vecs[7] = mk(16'h8000, 1, 8'h80, 8'h00, 1'b0);
`else
      vecs[4] = mk(16'h1234, 2, 8'h12, 8'h34, 1'b0);
      vecs[5] = mk(16'h0080, 2, 8'h00, 8'h80, 1'b0);
      vecs[6] = mk(16'hFF7F, 2, 8'hFF, 8'h7F, 1'b0);
      vecs[7] = mk(16'h8000, 2, 8'h80, 8'h00, 1'b0);
`endif

      bif.in_valid = 1'b0; bif.in_16b = '0; bif.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", bif.out_valid, 0);
      chk("rst_out_8b", bif.out_8b, 0);
      chk("rst_out_last", bif.out_last, 0);
      chk("rst_out_fits", bif.out_fits, 0);
      chk("rst_in_ready", bif.in_ready, 1);
      chk("rst_ovf", ovf1, 0);
      rst_n = 1'b1;

      // Single values with a free-running consumer.
      for (int i = 0; i < 8; i++) begin
         cap.delete();
         step(1'b1, vecs[i].val, 1'b1);
         step(1'b0, 16'h0, 1'b1);
         step(1'b0, 16'h0, 1'b1);
         chk("vec_nbeats", cap.size(), vecs[i].n);
         if (cap.size() == vecs[i].n) begin
            chk("vec_b0", cap[0].d, vecs[i].b0);
            chk("vec_b0_last", cap[0].last, vecs[i].n == 1);
            chk("vec_b0_fits", cap[0].fits, vecs[i].fits);
            if (vecs[i].n == 2) begin
               chk("vec_b1", cap[1].d, vecs[i].b1);
               chk("vec_b1_last", cap[1].last, 1);
            end
         end
      end

      // Back-to-back singles: one beat per cycle, in_ready never drops.
      cap.delete();
      step(1'b1, 16'h0005, 1'b1); chk("stream_rdy0", seen_ready, 1);
      step(1'b1, 16'h007F, 1'b1); chk("stream_rdy1", seen_ready, 1);
      step(1'b1, 16'hFF80, 1'b1); chk("stream_rdy2", seen_ready, 1);
      step(1'b0, 16'h0, 1'b1);
      chk("stream_n", cap.size(), 3);
      if (cap.size() == 3) begin
         chk("stream_b0", cap[0].d, 8'h05);
         chk("stream_b1", cap[1].d, 8'h7F);
         chk("stream_b2", cap[2].d, 8'h80);
         chk("stream_consec", cap[2].cyc - cap[0].cyc, 2);
      end

      // Stalled consumer holds the first beat; offered inputs are refused.
      cap.delete();
      step(1'b1, 16'h8000, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 16'h0011, 1'b0);
         chk("stall_8b", bif.out_8b, 8'h80);
         chk("stall_rdy", seen_ready, 0);
      end
      step(1'b0, 16'h0, 1'b1);
      step(1'b0, 16'h0, 1'b1);
      step(1'b0, 16'h0, 1'b1);
`ifdef IMM_SPLITTER_SATURATE_EN
      chk("stall_n", cap.size(), 1);
`else
      chk("stall_n", cap.size(), 2);
      if (cap.size() == 2) chk("stall_b1", cap[1].d, 8'h00);
`endif

      // Reset while the first half of a split is pending.
      step(1'b1, 16'h1234, 1'b0);
      @(posedge clk);
      #2;
      bif.in_valid = 1'b0;
      chk("pre_rst_8b", bif.out_8b, q[0].d);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", bif.out_valid, 0);
      chk("mid_rst_8b", bif.out_8b, 0);
      chk("mid_rst_last", bif.out_last, 0);
      chk("mid_rst_fits", bif.out_fits, 0);
      chk("mid_rst_ready", bif.in_ready, 1);
      chk("mid_rst_ovf", ovf1, 0);
      q.delete();
      ovf_m = 0;
      @(negedge clk);
      rst_n = 1'b1;
      cap.delete();
      repeat (3) step(1'b0, 16'h0, 1'b1);
      chk("post_rst_nolo", cap.size(), 0);
      step(1'b1, 16'h0001, 1'b1);
      step(1'b0, 16'h0, 1'b1);
      step(1'b0, 16'h0, 1'b1);
      chk("post_rst_n", cap.size(), 1);
      if (cap.size() == 1) chk("post_rst_b", cap[0].d, 8'h01);

      // Narrow counter saturates at 3.
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 16'h1000 + 16'(i), 1'b1);
         step(1'b0, 16'h0, 1'b1);
         step(1'b0, 16'h0, 1'b1);
      end
      chk("sat_cnt_w2", ovf2, 3);
      chk("sat_cnt_w8", ovf1, 5);
      repeat (3) step(1'b0, 16'h0, 1'b1);
      chk("sat_cnt_hold", ovf2, 3);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         logic [7:0]  b;
         logic [15:0] v;
         b = 8'($urandom);
         v = ($urandom % 2 == 0) ? {{8{b[7]}}, b} : 16'($urandom);
         step(($urandom % 4) != 0, v, ($urandom % 4) != 0);
      end
      repeat (6) step(1'b0, 16'h0, 1'b1);
      chk("drain_empty", q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/imm_splitter.md
IMM_SPLITTER -- requirements
Module: imm_splitter

Interface
REQ-001 Parameter CNT_W, default 8: width of the out-of-range event counter.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  in_16b holds a value to encode.
REQ-005 in_16b  input  16  two's-complement value to narrow into 8-bit immediate field(s).
REQ-006 in_ready  output  1  block accepts in_16b this cycle.
REQ-007 out_valid  output  1  out_8b beat valid.
REQ-008 out_ready  input  1  consumer takes the beat this cycle.
REQ-009 out_8b  output  8  immediate field beat.
REQ-010 out_last  output  1  final beat of the current value.
REQ-011 out_fits  output  1  value is exactly representable as a sign-extended 8-bit immediate.
REQ-012 ovf_cnt  output  CNT_W  count of accepted values that did not fit.

Function
REQ-013 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-014 Fit test: value fits iff in_16b[15:7] is all zeros or all ones.
REQ-015 FSM states IDLE, ONE, HI, LO; reset state IDLE.
REQ-016 IDLE: out_valid=0, in_ready=1; an input transfer goes to ONE if the value fits, else to HI.
REQ-017 ONE: out_8b=in_16b[7:0] registered, out_last=1, out_fits=1.
REQ-018 HI: out_8b=in_16b[15:8] registered, out_last=0, out_fits=0; an output transfer goes to LO.
REQ-019 LO: out_8b=in_16b[7:0] registered, out_last=1, out_fits=0.
REQ-020 In ONE or LO: an output transfer with in_valid=0 goes to IDLE.
REQ-021 in_ready = (state==IDLE) || (out_valid && out_ready && out_last), so back-to-back single-beat values stream at one value per cycle.
REQ-022 Simultaneous last-beat output transfer and input transfer: the new value loads in the same edge and the next state is ONE or HI with no bubble.
REQ-023 With out_ready=0, out_8b, out_last and out_fits hold stable and no input is accepted.
REQ-024 Latency: first beat is valid the cycle after the input transfer.
REQ-025 ovf_cnt increments by 1 on each input transfer of a non-fitting value, saturates at all-ones, and never wraps.
REQ-026 Consumer reconstructs a split value as {hi_beat, lo_beat}; a single beat is recovered by sign-extending it to 16 bits.

Reset
REQ-027 Asserting rst_n low immediately forces state=IDLE, out_valid=0, out_8b=0, out_last=0, out_fits=0, ovf_cnt=0, and the held value=0; in_ready becomes 1 as a consequence of state IDLE.
REQ-028 Reset in HI or LO discards the partial value, and no LO beat is emitted afterward.

Configuration
REQ-029 Macro IMM_SPLITTER_SATURATE_EN: when defined, a non-fitting value does not split and goes to ONE with out_8b=8'h7F (positive) or 8'h80 (negative), out_last=1, out_fits=0; HI and LO are unreachable.
REQ-030 Without IMM_SPLITTER_SATURATE_EN, the split behaviour of REQ-016 to REQ-019 applies.
REQ-031 ovf_cnt counting is identical with and without IMM_SPLITTER_SATURATE_EN.

Structure
REQ-032 Shared package imm_pkg holds the state enum typedef (IDLE, ONE, HI, LO), IMM_W=8, DATA_W=16, and constants SAT_POS=8'h7F and SAT_NEG=8'h80.
REQ-033 One sub-module imm_fit_check (combinational fit test and saturation value) is instantiated once; all sequencing stays in imm_splitter.

Verification
REQ-034 in 16'hFFF0 with out_ready=1 -> one beat 8'hF0, out_last=1, out_fits=1; ovf_cnt stays 0.
REQ-035 in 16'h1234 -> beats 8'h12 (last=0) then 8'h34 (last=1), out_fits=0; ovf_cnt=1 (split build); single beat 8'h7F, out_fits=0 (SATURATE build).
REQ-036 Stream 16'h0005, 16'h007F, 16'hFF80 with in_valid and out_ready held at 1 -> beats 05, 7F, 80 on three consecutive cycles with in_ready held at 1.
REQ-037 in 16'h8000, out_ready=0 for 5 cycles -> 8'h80 held stable with in_ready=0; release -> 8'h00 beat follows.
REQ-038 Assert rst_n low in HI state for input 16'h1234 -> all outputs return to reset values, no 8'h34 beat appears, and the next input 16'h0001 yields the single beat 8'h01.
REQ-039 With CNT_W=2, apply 5 non-fitting values -> ovf_cnt reads 3 and holds at 3.
